seq_sdiv48: RTL and testbench

- Iterative signed divider; the inverse direction of the DSP48E1 multiply path (P = A*B).
- Takes a 48-bit signed product-width dividend and an 18-bit signed divisor.
- Recovers a 25-bit signed quotient (A-port width) and an 18-bit remainder.
- Used wherever a P-domain result must be scaled back to A-domain; one bit per cycle, no DSP slice consumed.

---
 rtl/seq_sdiv48_if.sv | 28 ++
 rtl/seq_sdiv48.sv | 137 +++++++++++++
 tb/tb_seq_sdiv48.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_sdiv48_if.sv
// Operand/result handshake bundle for the seq_sdiv48 iterative signed divider.
// The master side issues operands and consumes results; the slave is the divider.
interface seq_sdiv48_if #(
   parameter int DW = 48,
   parameter int VW = 18,
   parameter int QW = 25
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;
   logic          ovf;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero, ovf
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero, ovf
   );
endinterface

// File: rtl/seq_sdiv48.sv
// Restoring signed divider, one quotient bit per cycle: P-width dividend / B-width divisor.
// Define SEQ_SDIV48_SAT_EN to saturate an out-of-range quotient and raise ovf; otherwise it wraps.
module seq_sdiv48 #(
   parameter int DW = 48,
   parameter int VW = 18,
   parameter int QW = 25
) (
   input logic         clk,
   input logic         rst,
   seq_sdiv48_if.slave bus
);
   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          sign_n, sign_q, v_zero;
   logic [DW-1:0] num;       // dividend magnitude; quotient bits shift in from the bottom
   logic [VW-1:0] vmag;
   logic [VW:0]   prem;

   logic [QW-1:0] quotient_r;
   logic [VW-1:0] remainder_r;
   logic          div_zero_r, ovf_r;

   wire accept = bus.in_valid && (state == IDLE);
   wire retire = bus.out_ready && (state == DONE);

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
   assign bus.div_zero  = div_zero_r;
   assign bus.ovf       = ovf_r;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nx and no latch is inferred.
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nx = CALC;
         CALC:    if (cnt == '0)     state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
   logic [VW+1:0] shifted, trial;
   logic          q_bit;
   logic [VW:0]   prem_nx;
   logic [DW-1:0] qmag_nx;

   always_comb begin
      shifted = {prem, num[DW-1]};
      trial   = shifted - {2'b00, vmag};
      q_bit   = ~trial[VW+1];
      prem_nx = q_bit ? trial[VW:0] : shifted[VW:0];
      qmag_nx = {num[DW-2:0], q_bit};
   end

   // Signed result from the final magnitudes, reduced to QW bits.
   logic [QW-1:0] q_res;
   logic          ovf_res;
   logic [VW-1:0] r_res;

`ifdef SEQ_SDIV48_SAT_EN
   logic [DW:0] q_full;
   logic        q_fits;

   always_comb begin
      q_full  = sign_q ? -{1'b0, qmag_nx} : {1'b0, qmag_nx};
      q_fits  = (&q_full[DW:QW-1]) || !(|q_full[DW:QW-1]);
      ovf_res = !q_fits;
      if (q_fits)      q_res = q_full[QW-1:0];
      else if (sign_q) q_res = {1'b1, {(QW-1){1'b0}}};
      else             q_res = {1'b0, {(QW-1){1'b1}}};
   end
`else
   always_comb begin
      q_res   = sign_q ? QW'(-qmag_nx) : QW'(qmag_nx);
      ovf_res = 1'b0;
   end
`endif

   assign r_res = sign_n ? VW'(-prem_nx) : VW'(prem_nx);

   // NOTE: these are individual flops, not a memory, so each one takes the async reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt         <= '0;
         sign_n      <= 1'b0;
         sign_q      <= 1'b0;
         v_zero      <= 1'b0;
         num         <= '0;
         vmag        <= '0;
         prem        <= '0;
         quotient_r  <= '0;
         remainder_r <= '0;
         div_zero_r  <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         if (accept) begin
            sign_n <= bus.dividend[DW-1];
            sign_q <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
            v_zero <= (bus.divisor == '0);
            // Unsigned negation keeps the most negative operand's magnitude exact.
            num    <= bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
            vmag   <= bus.divisor[VW-1]  ? -bus.divisor  : bus.divisor;
            prem   <= '0;
            cnt    <= CW'(DW - 1);
         end else if (state == CALC) begin
            prem <= prem_nx;
            num  <= qmag_nx;
            cnt  <= cnt - CW'(1);
            if (cnt == '0) begin
               // A zero divisor still runs the full pass; its garbage magnitudes are discarded.
               quotient_r  <= v_zero ? '0 : q_res;
               remainder_r <= v_zero ? '0 : r_res;
               div_zero_r  <= v_zero;
               ovf_r       <= v_zero ? 1'b0 : ovf_res;
            end
         end else if (retire) begin
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
            ovf_r       <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seq_sdiv48.sv
// Scoreboard bench for seq_sdiv48: stimulus pushes model results, a monitor pops on each accepted result.
// Build with SEQ_SDIV48_SAT_EN to match a saturating DUT build.
module tb_seq_sdiv48;
   localparam int DW = 48;
   localparam int VW = 18;
   localparam int QW = 25;

   typedef struct {
      logic [QW-1:0] q;
      logic [VW-1:0] r;
      logic          dz;
      logic          ov;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_sdiv48_if #(.DW(DW), .VW(VW), .QW(QW)) bus ();
   seq_sdiv48 #(.DW(DW), .VW(VW), .QW(QW)) dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   hold_low   = 1'b0;
   bit   rand_ready = 1'b0;

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Reference: plain signed integer division, truncating toward zero.
   function automatic exp_t model(input logic signed [DW-1:0] a, input logic signed [VW-1:0] b);
      exp_t   e;
      longint n, d, q, r, lo, hi, q_out;
      n  = a;
      d  = b;
      lo = -(longint'(1) <<< (QW - 1));
      hi = (longint'(1) <<< (QW - 1)) - 1;
      if (d == 0) begin
         e.q = '0; e.r = '0; e.dz = 1'b1; e.ov = 1'b0;
         return e;
      end
      q = n / d;
      r = n % d;
`ifdef SEQ_SDIV48_SAT_EN
      e.ov  = (q < lo) || (q > hi);
      q_out = e.ov ? ((q < 0) ? lo : hi) : q;
`else
      e.ov  = 1'b0;
      q_out = q;
`endif
      e.q  = QW'(q_out);
      e.r  = VW'(r);
      e.dz = 1'b0;
      return e;
   endfunction

   // Monitor: a result is consumed at the edge after a negedge that sees valid && ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got quotient %0d, expected no result", $signed(bus.quotient));
            end else begin
               e = sb_q.pop_front();
               check("quotient",  $signed(bus.quotient),  $signed(e.q));
               check("remainder", $signed(bus.remainder), $signed(e.r));
               check("div_zero",  bus.div_zero,           e.dz);
               check("ovf",       bus.ovf,                e.ov);
            end
         end
      end
   end

   // Result-side ready driver.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   task automatic issue(input logic signed [DW-1:0] a, input logic signed [VW-1:0] b);
      int t = 0;
      while (bus.in_ready !== 1'b1 && t < 500) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 500) flag_timeout("in_ready_wait");
      bus.dividend = a;
      bus.divisor  = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      sb_q.push_back(model(a, b));
   endtask

   // Counts rising edges from the accept edge (edge 1) to the one after which out_valid is high.
   task automatic wait_valid(output int n);
      n = 1;
      while (bus.out_valid !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 200) flag_timeout("out_valid_wait");
   endtask

   task automatic drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 2000) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 2000) flag_timeout("scoreboard_drain");
   endtask

   initial begin
      int   lat;
      exp_t e;
      logic signed [DW-1:0] a;
      logic signed [VW-1:0] b;

      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_quotient",  bus.quotient,  0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_div_zero",  bus.div_zero,  0);
      check("rst_ovf",       bus.ovf,       0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic operation and latency.
      issue(48'sd20000, 18'sd200);
      wait_valid(lat);
      check("latency_basic", lat, DW + 1);
      drain();

      // Sign combinations.
      issue(-48'sd20001, 18'sd200);
      issue(48'sd20001, -18'sd200);
      issue(-48'sd20001, -18'sd200);
      drain();

      // Divide by zero keeps the full latency.
      issue(48'sd7, 18'sd0);
      wait_valid(lat);
      check("latency_div_zero", lat, DW + 1);
      drain();

      // Range extremes.
      issue(48'sh8000_0000_0000, 18'sd1);
      issue(48'sh8000_0000_0000, -18'sd1);
      issue(48'sh7FFF_FFFF_FFFF, -18'sd131072);
      issue(48'sd16777215, 18'sd1);
      issue(-48'sd16777216, 18'sd1);
      issue(48'sd16777216, 18'sd1);
      issue(-48'sd1, -18'sd131072);
      drain();

      // Backpressure: result held with out_ready low.
      hold_low = 1'b1;
      @(posedge clk); #1;
      issue(48'sd123456789, -18'sd77);
      wait_valid(lat);
      e = model(48'sd123456789, -18'sd77);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready",  bus.in_ready,  0);
         check("bp_quotient",  $signed(bus.quotient),  $signed(e.q));
         check("bp_remainder", $signed(bus.remainder), $signed(e.r));
      end
      hold_low = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #1;
      check("bp_release_in_ready",  bus.in_ready,  1);
      check("bp_release_out_valid", bus.out_valid, 0);
      issue(48'sd17179869184, -18'sd131072);
      drain();

      // Asynchronous reset in the middle of CALC aborts the operation.
      issue(48'sd20000, 18'sd200);
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_in_ready",  bus.in_ready,  1);
      check("abort_quotient",  bus.quotient,  0);
      check("abort_remainder", bus.remainder, 0);
      check("abort_div_zero",  bus.div_zero,  0);
      check("abort_ovf",       bus.ovf,       0);
      if (sb_q.size() != 0) void'(sb_q.pop_back());
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      issue(48'sd20000, 18'sd200);
      drain();

      // Randomized operands with random consumer stalls.
      rand_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         a = DW'({$urandom(), $urandom()});
         a = a >>> $urandom_range(0, 40);
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = ($urandom_range(0, 1) != 0) ? 18'sd1 : -18'sd1;
            2:       b = -18'sd131072;
            default: begin
               b = VW'($urandom());
               b = b >>> $urandom_range(0, 16);
            end
         endcase
         issue(a, b);
      end
      drain();
      rand_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end
endmodule
